// File: rtl/kv_filter_db.sv
// Key/status table responder for the DNS-amplification filter: direct-mapped flow table,
// fixed 3-cycle lookup/update pipeline with write-forwarding for back-to-back requests.
module kv_filter_db #(
    parameter int KEY_SIZE   = 96,
    parameter int HASH_SIZE  = 10,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk156,
    input  logic                  eth_rst,
    input  logic [KEY_SIZE-1:0]   in_key,
    input  logic [3:0]            in_flag,
    input  logic                  in_valid,
    output logic                  out_valid,
    output logic [3:0]            out_flag,
    output logic                  init_done,
    output logic [STAT_WIDTH-1:0] stat_insert,
    output logic [STAT_WIDTH-1:0] stat_arrest,
    output logic [STAT_WIDTH-1:0] stat_drop
);

    localparam int DEPTH  = 2 ** HASH_SIZE;
    localparam int ENT_W  = KEY_SIZE + 2;
    localparam int NCHUNK = (KEY_SIZE + HASH_SIZE - 1) / HASH_SIZE;
    localparam int PAD_W  = NCHUNK * HASH_SIZE;

    localparam logic [1:0] ST_EMPTY   = 2'b00;
    localparam logic [1:0] ST_SUSPECT = 2'b01;
    localparam logic [1:0] ST_ARREST  = 2'b10;
    localparam logic [1:0] OP_SUSPECT = 2'b01;
    localparam logic [1:0] OP_ARREST  = 2'b10;
    localparam logic [1:0] OP_QUERY   = 2'b11;

    typedef enum logic {S_INIT, S_RUN} state_t;

    function automatic logic [HASH_SIZE-1:0] fold_key(input logic [KEY_SIZE-1:0] key);
        logic [HASH_SIZE-1:0] h;
        logic [PAD_W-1:0]     p;
        h = '0;
        p = PAD_W'(key);
        for (int c = 0; c < NCHUNK; c++) begin
            h = h ^ p[HASH_SIZE-1:0];
            p = p >> HASH_SIZE;
        end
        return h;
    endfunction

    state_t                 state_q, state_d;
    logic [HASH_SIZE-1:0]   init_cnt_q, init_cnt_d;
    logic                   init_done_q, init_done_d;
    logic                   init_we;

    logic [ENT_W-1:0]       mem [DEPTH];
    logic                   tbl_we;
    logic [HASH_SIZE-1:0]   tbl_addr;
    logic [ENT_W-1:0]       tbl_wdata;

    logic                   vld_p0, vld_p1, vld_p2;
    logic                   run_p0, run_p1;
    logic [1:0]             op_p0, op_p1;
    logic [KEY_SIZE-1:0]    key_p0, key_p1;
    logic [HASH_SIZE-1:0]   idx_p0, idx_p1;
    logic [ENT_W-1:0]       rd_ent_p1;
    logic [3:0]             flag_p2;

    logic                   fwd1_vld_q, fwd2_vld_q;
    logic [HASH_SIZE-1:0]   fwd1_idx_q, fwd2_idx_q;
    logic [ENT_W-1:0]       fwd1_ent_q, fwd2_ent_q;

    logic [ENT_W-1:0]       cur_ent;
    logic [1:0]             cur_stat;
    logic [KEY_SIZE-1:0]    cur_key;
    logic                   hit;
    logic [1:0]             res;
    logic [1:0]             wr_stat;
    logic [ENT_W-1:0]       wr_ent;
    logic                   run_we, inc_ins, inc_arr, inc_drop;

    logic [STAT_WIDTH-1:0]  stat_insert_q, stat_arrest_q, stat_drop_q;

    logic                   unused_flag3;
    assign unused_flag3 = in_flag[3];

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        init_we     = 1'b0;
        case (state_q)
            S_INIT: begin
                init_we    = 1'b1;
                init_cnt_d = init_cnt_q + HASH_SIZE'(1);
                if (&init_cnt_q) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // S0: capture request; a missing marker bit degrades the request to a no-op
    always_ff @(posedge clk156) begin
        run_p0 <= (state_q == S_RUN);
        op_p0  <= in_flag[0] ? in_flag[2:1] : 2'b00;
        key_p0 <= in_key;
        idx_p0 <= fold_key(in_key);
    end

    // S1: table read; the sweep and S2 updates share the single write port
    assign tbl_we    = init_we | run_we;
    assign tbl_addr  = init_we ? init_cnt_q : idx_p1;
    assign tbl_wdata = init_we ? {ENT_W{1'b0}} : wr_ent;

    always_ff @(posedge clk156) begin
        if (!eth_rst && tbl_we) mem[tbl_addr] <= tbl_wdata;
        rd_ent_p1 <= mem[idx_p0];
        run_p1    <= run_p0;
        op_p1     <= op_p0;
        key_p1    <= key_p0;
        idx_p1    <= idx_p0;
    end

    // S2: newest in-flight write to the same slot overrides the (possibly stale) read
    always_comb begin
        cur_ent = rd_ent_p1;
        if (fwd1_vld_q && fwd1_idx_q == idx_p1)      cur_ent = fwd1_ent_q;
        else if (fwd2_vld_q && fwd2_idx_q == idx_p1) cur_ent = fwd2_ent_q;
    end

    assign cur_stat = cur_ent[ENT_W-1 -: 2];
    assign cur_key  = cur_ent[KEY_SIZE-1:0];
    assign hit      = (cur_stat != ST_EMPTY) && (cur_key == key_p1);
    assign wr_ent   = {wr_stat, key_p1};

    always_comb begin
        res      = ST_EMPTY;
        wr_stat  = ST_SUSPECT;
        run_we   = 1'b0;
        inc_ins  = 1'b0;
        inc_arr  = 1'b0;
        inc_drop = 1'b0;
        if (vld_p1 && run_p1) begin
            case (op_p1)
                OP_SUSPECT: begin
                    if (hit) begin
                        res = cur_stat;
                    end else if (cur_stat == ST_ARREST) begin
                        res      = ST_SUSPECT;
                        inc_drop = 1'b1;
                    end else begin
                        res     = ST_SUSPECT;
                        run_we  = 1'b1;
                        inc_ins = 1'b1;
                    end
                end
                OP_ARREST: begin
                    if (hit) begin
                        res = ST_ARREST;
                        if (cur_stat == ST_SUSPECT) begin
                            wr_stat = ST_ARREST;
                            run_we  = 1'b1;
                            inc_arr = 1'b1;
                        end
                    end
                end
                OP_QUERY: if (hit) res = cur_stat;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk156) begin
        fwd1_idx_q <= idx_p1;
        fwd1_ent_q <= wr_ent;
        fwd2_idx_q <= fwd1_idx_q;
        fwd2_ent_q <= fwd1_ent_q;
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            flag_p2       <= 4'b0000;
            fwd1_vld_q    <= 1'b0;
            fwd2_vld_q    <= 1'b0;
            stat_insert_q <= '0;
            stat_arrest_q <= '0;
            stat_drop_q   <= '0;
        end else begin
            vld_p0     <= in_valid;
            vld_p1     <= vld_p0;
            vld_p2     <= vld_p1;
            flag_p2    <= (vld_p1 && run_p1) ? {1'b0, res, 1'b1} : 4'b0000;
            fwd1_vld_q <= run_we;
            fwd2_vld_q <= fwd1_vld_q;
            if (inc_ins)  stat_insert_q <= stat_insert_q + STAT_WIDTH'(1);
            if (inc_arr)  stat_arrest_q <= stat_arrest_q + STAT_WIDTH'(1);
            if (inc_drop) stat_drop_q   <= stat_drop_q + STAT_WIDTH'(1);
        end
    end

    assign out_valid   = vld_p2;
    assign out_flag    = flag_p2;
    assign init_done   = init_done_q;
    assign stat_insert = stat_insert_q;
    assign stat_arrest = stat_arrest_q;
    assign stat_drop   = stat_drop_q;

endmodule

// File: tb/tb_kv_filter_db.sv
// Directed bench for kv_filter_db: init sweep, lookup/update decisions, collisions,
// back-to-back forwarding and reset with requests in flight.
module tb_kv_filter_db;

    logic        clk156;
    logic        eth_rst;
    logic [95:0] in_key;
    logic [3:0]  in_flag;
    logic        in_valid;
    logic        out_valid;
    logic [3:0]  out_flag;
    logic        init_done;
    logic [15:0] stat_insert, stat_arrest, stat_drop;

    int total = 0;
    int bad   = 0;
    int cyc;
    int spurious;

    localparam logic [1:0] OP_NOP = 2'b00, OP_SUS = 2'b01, OP_ARR = 2'b10, OP_QRY = 2'b11;

    // Index of each key noted alongside; KA/KB, K4/K5, K6/K7 share slots
    localparam logic [95:0] K1  = 96'h0000_0000_0000_0000_0010_0000; // idx 1
    localparam logic [95:0] K2  = 96'h0000_0000_0000_0000_0020_0000; // idx 2
    localparam logic [95:0] K3  = 96'h0000_0000_0000_2001_0040_0000; // idx 32
    localparam logic [95:0] K10 = 96'h0000_0000_0000_0000_0080_0000; // idx 8
    localparam logic [95:0] KA  = 96'h0000_0000_0000_0000_0004_0000; // idx 256
    localparam logic [95:0] KB  = 96'h0000_0000_0000_0000_1000_0000; // idx 256
    localparam logic [95:0] K4  = 96'h0000_0000_0000_0000_0001_0000; // idx 64
    localparam logic [95:0] K5  = 96'h0000_0000_0000_0000_0400_0000; // idx 64
    localparam logic [95:0] K6  = 96'h0000_0000_0000_0000_0002_0000; // idx 128
    localparam logic [95:0] K7  = 96'h0000_0000_0000_0000_0800_0000; // idx 128
    localparam logic [95:0] K8  = 96'h0000_0000_0000_0000_0100_0000; // idx 16
    localparam logic [95:0] K9  = 96'h0000_0000_0000_0000_0200_0000; // idx 32

    kv_filter_db #(.KEY_SIZE(96), .HASH_SIZE(10), .STAT_WIDTH(16)) dut (
        .clk156     (clk156),
        .eth_rst    (eth_rst),
        .in_key     (in_key),
        .in_flag    (in_flag),
        .in_valid   (in_valid),
        .out_valid  (out_valid),
        .out_flag   (out_flag),
        .init_done  (init_done),
        .stat_insert(stat_insert),
        .stat_arrest(stat_arrest),
        .stat_drop  (stat_drop)
    );

    initial clk156 = 1'b0;
    always #5 clk156 = ~clk156;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [95:0] k, input logic [3:0] f);
        in_valid = v;
        in_key   = k;
        in_flag  = f;
    endtask

    // One request from a negedge; response expected three edges later, single pulse
    task automatic req_check(input string tag, input logic [95:0] k, input logic [3:0] f,
                             input logic [3:0] exp);
        drive(1'b1, k, f);
        @(negedge clk156);
        drive(1'b0, '0, 4'b0000);
        @(negedge clk156);
        chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk156);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_flag"}, {28'd0, out_flag}, {28'd0, exp});
        @(negedge clk156);
        chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic burst3(input string tag, input logic [2:0] vm,
                          input logic [95:0] k0, input logic [1:0] o0, input logic [3:0] e0,
                          input logic [95:0] k1, input logic [1:0] o1, input logic [3:0] e1,
                          input logic [95:0] k2, input logic [1:0] o2, input logic [3:0] e2);
        drive(vm[0], k0, {1'b0, o0, 1'b1});
        @(negedge clk156);
        drive(vm[1], k1, {1'b0, o1, 1'b1});
        @(negedge clk156);
        drive(vm[2], k2, {1'b0, o2, 1'b1});
        @(negedge clk156);
        drive(1'b0, '0, 4'b0000);
        chk({tag, "_v0"}, {31'd0, out_valid}, {31'd0, vm[0]});
        if (vm[0]) chk({tag, "_f0"}, {28'd0, out_flag}, {28'd0, e0});
        @(negedge clk156);
        chk({tag, "_v1"}, {31'd0, out_valid}, {31'd0, vm[1]});
        if (vm[1]) chk({tag, "_f1"}, {28'd0, out_flag}, {28'd0, e1});
        @(negedge clk156);
        chk({tag, "_v2"}, {31'd0, out_valid}, {31'd0, vm[2]});
        if (vm[2]) chk({tag, "_f2"}, {28'd0, out_flag}, {28'd0, e2});
        @(negedge clk156);
        chk({tag, "_tail"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic chk_stats(input string tag, input int ins, input int arr, input int drp);
        chk({tag, "_ins"}, {16'd0, stat_insert}, ins);
        chk({tag, "_arr"}, {16'd0, stat_arrest}, arr);
        chk({tag, "_drop"}, {16'd0, stat_drop}, drp);
    endtask

    initial begin
        eth_rst = 1'b1;
        drive(1'b0, '0, 4'b0000);
        repeat (3) @(negedge clk156);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_flag", {28'd0, out_flag}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk_stats("rst", 0, 0, 0);

        // First sweep: count samples with init_done low, starting at the last reset edge
        eth_rst  = 1'b0;
        cyc      = 0;
        spurious = 0;
        for (int i = 0; i < 3000; i++) begin
            if (init_done) break;
            if (out_valid) spurious++;
            cyc++;
            @(negedge clk156);
        end
        chk("sweep1_len", cyc, 1024);
        chk("sweep1_no_out", spurious, 0);
        chk_stats("after_init", 0, 0, 0);
        @(negedge clk156);
        chk("init_done_stays", {31'd0, init_done}, 32'd1);

        req_check("k1_sus", K1, {1'b0, OP_SUS, 1'b1}, 4'b0011);
        chk_stats("k1_sus", 1, 0, 0);
        req_check("k1_arr", K1, {1'b0, OP_ARR, 1'b1}, 4'b0101);
        chk_stats("k1_arr", 1, 1, 0);
        req_check("k1_sus2", K1, {1'b0, OP_SUS, 1'b1}, 4'b0101);
        req_check("k1_qry", K1, {1'b0, OP_QRY, 1'b1}, 4'b0101);
        chk_stats("k1_done", 1, 1, 0);

        req_check("k2_arr_miss", K2, {1'b0, OP_ARR, 1'b1}, 4'b0001);
        chk_stats("k2_arr_miss", 1, 1, 0);
        req_check("k2_sus", K2, {1'b0, OP_SUS, 1'b1}, 4'b0011);
        req_check("k2_qry", K2, {1'b0, OP_QRY, 1'b1}, 4'b0011);
        chk_stats("k2_done", 2, 1, 0);

        burst3("k3_b2b", 3'b111,
               K3, OP_SUS, 4'b0011, K3, OP_ARR, 4'b0101, K3, OP_SUS, 4'b0101);
        chk_stats("k3_b2b", 3, 2, 0);
        burst3("k10_gap", 3'b101,
               K10, OP_SUS, 4'b0011, K10, OP_NOP, 4'b0000, K10, OP_QRY, 4'b0011);
        burst3("ab_b2b", 3'b111,
               KA, OP_SUS, 4'b0011, KB, OP_QRY, 4'b0001, KA, OP_QRY, 4'b0011);
        chk_stats("bursts", 5, 2, 0);

        req_check("k4_sus", K4, {1'b0, OP_SUS, 1'b1}, 4'b0011);
        req_check("k4_arr", K4, {1'b0, OP_ARR, 1'b1}, 4'b0101);
        req_check("k5_drop", K5, {1'b0, OP_SUS, 1'b1}, 4'b0011);
        chk_stats("k5_drop", 6, 3, 1);
        req_check("k4_qry", K4, {1'b0, OP_QRY, 1'b1}, 4'b0101);
        req_check("k5_qry", K5, {1'b0, OP_QRY, 1'b1}, 4'b0001);

        req_check("k6_sus", K6, {1'b0, OP_SUS, 1'b1}, 4'b0011);
        req_check("k7_evict", K7, {1'b0, OP_SUS, 1'b1}, 4'b0011);
        chk_stats("k7_evict", 8, 3, 1);
        req_check("k6_qry", K6, {1'b0, OP_QRY, 1'b1}, 4'b0001);
        req_check("k7_qry", K7, {1'b0, OP_QRY, 1'b1}, 4'b0011);

        req_check("nop_op", K1, 4'b0001, 4'b0001);
        req_check("no_marker_qry", K1, 4'b0110, 4'b0001);
        req_check("no_marker_sus", K8, 4'b0010, 4'b0001);
        req_check("k8_qry", K8, {1'b0, OP_QRY, 1'b1}, 4'b0001);
        chk_stats("nops", 8, 3, 1);

        // Reset lands on the edge that would emit the first of three in-flight responses
        drive(1'b1, K8, {1'b0, OP_SUS, 1'b1});
        @(negedge clk156);
        drive(1'b1, K9, {1'b0, OP_SUS, 1'b1});
        @(negedge clk156);
        drive(1'b1, K8, {1'b0, OP_ARR, 1'b1});
        eth_rst = 1'b1;
        @(negedge clk156);
        eth_rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_init_done", {31'd0, init_done}, 32'd0);
        chk_stats("midrst", 0, 0, 0);

        // Request during the restarted sweep; samples here count toward the sweep length
        drive(1'b1, K1, {1'b0, OP_QRY, 1'b1});
        cyc = 1;
        @(negedge clk156);
        drive(1'b0, '0, 4'b0000);
        chk("init_req_q1", {31'd0, out_valid}, 32'd0);
        cyc++;
        @(negedge clk156);
        chk("init_req_q2", {31'd0, out_valid}, 32'd0);
        cyc++;
        @(negedge clk156);
        chk("init_req_vld", {31'd0, out_valid}, 32'd1);
        chk("init_req_flag", {28'd0, out_flag}, 32'd0);
        cyc++;
        spurious = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk156);
            if (init_done) break;
            if (out_valid) spurious++;
            cyc++;
        end
        chk("sweep2_len", cyc, 1024);
        chk("sweep2_no_out", spurious, 0);
        chk_stats("sweep2", 0, 0, 0);

        req_check("wiped_k1", K1, {1'b0, OP_QRY, 1'b1}, 4'b0001);
        req_check("wiped_k8", K8, {1'b0, OP_QRY, 1'b1}, 4'b0001);
        req_check("k1_reins", K1, {1'b0, OP_SUS, 1'b1}, 4'b0011);
        chk_stats("final", 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kv_filter_db.md
Name: kv_filter_db

Overview:
- Lookup/update responder for the DNS-amplification filter key-value interface.
- Accepts single-cycle requests (in_key, in_flag, in_valid) from the Ethernet parser.
- Keeps a direct-mapped table of flow keys, each with a 2-bit status.
- Answers every request with exactly one out_valid/out_flag pulse at a fixed latency. The parser blocks suspect-path traffic when out_flag[2:1] == 2'b10.

Parameters:
KEY_SIZE, 96, request key width {src_ip, dst_ip, dst_port, 16'd0}
HASH_SIZE, 10, table index width; DEPTH = 2**HASH_SIZE entries
STAT_WIDTH, 16, width of statistics counters

Ports:
clk156  in  1  system clock; single clock domain
eth_rst  in  1  synchronous, active-high reset
in_key  in  KEY_SIZE  request key
in_flag  in  4  request opcode: [0]=request marker, [2:1]=op, [3]=reserved
in_valid  in  1  one-cycle request strobe; no ready, must be accepted every cycle
out_valid  out  1  one-cycle response strobe
out_flag  out  4  response: {1'b0, result_status[1:0], 1'b1}
init_done  out  1  high once the table sweep is complete
stat_insert  out  STAT_WIDTH  suspect entries inserted
stat_arrest  out  STAT_WIDTH  suspect-to-arrest upgrades
stat_drop  out  STAT_WIDTH  inserts refused because the slot held a different ARREST key

Behaviour:
- Status encoding: 00 EMPTY, 01 SUSPECT, 10 ARREST, 11 reserved; 11 is never written.
- Entry format: {status[1:0], key[KEY_SIZE-1:0]}. Table in inferred BRAM, one read port and one write port.
- Index: XOR-fold of in_key into consecutive HASH_SIZE-bit chunks, LSB first. The last partial chunk is zero-padded.
- Reset: out_valid=0, out_flag=0, init_done=0, all stat_* = 0, pipeline valid bits cleared. FSM enters INIT.
- FSM INIT: writes EMPTY to entries 0..DEPTH-1, one per cycle, taking DEPTH cycles.
  - After the last write: state RUN, init_done=1 on the next cycle; it then stays high until reset.
- Requests during INIT: still answered at normal latency with out_flag=4'b0000. The table is untouched.
- Pipeline with latency 3 (in_valid at cycle T produces out_valid at T+3):
  - S0: register key, op, index.
  - S1: BRAM read.
  - S2: compare, decide, write back, register the response.
- Decision in S2. hit = stored status != EMPTY and stored key == request key.
  - op 01 (SUSPECT):
    - hit ARREST: result 10, no write.
    - hit SUSPECT: result 01, no write.
    - Slot EMPTY or held by a different SUSPECT key: write {01,key} (eviction allowed), stat_insert+1, result 01.
    - Slot held by a different ARREST key: no write, stat_drop+1, result 01.
  - op 10 (ARREST):
    - hit SUSPECT: write {10,key}, stat_arrest+1, result 10.
    - hit ARREST: result 10, no write.
    - miss: result 00, no write.
  - op 11 (QUERY): result = stored status if hit, else 00; no write.
  - op 00 or in_flag[0]=0: result 00, no write; a response is still issued.
- Ordering hazard: back-to-back requests to the same index must produce results identical to serial processing in arrival order.
  - Required: forward the S2 write data into the S2 compare of the following one or two requests when their index matches.
  - The stale BRAM read must never be used.
- Counters wrap modulo 2**STAT_WIDTH.
- Reset mid-operation: in-flight requests are discarded; out_valid is 0 the cycle after reset is sampled. Re-enters INIT.
- Throughput: one request per cycle sustained, no stalls.

Test Plan:
- Reset → init_done low for exactly 1024 cycles (HASH_SIZE=10), then high. No out_valid without a request. Stats all 0.
- SUSPECT K1 at T → out_flag=4'b0011 at T+3, stat_insert=1. Then:
  - ARREST K1 → 4'b0101, stat_arrest=1.
  - SUSPECT K1 → 4'b0101.
  - QUERY K1 → 4'b0101.
- ARREST unknown K2 → 4'b0001 and no insert. Then SUSPECT K2 → 4'b0011, QUERY K2 → 4'b0011.
- Back-to-back K3: SUSPECT at T, ARREST at T+1, SUSPECT at T+2 → 0011, 0101, 0101 at T+3..T+5 (forwarding check).
- Collision, K4 and K5 sharing an index:
  - K4 arrested; SUSPECT K5 → 0011, stat_drop=1; QUERY K4 → 0101, QUERY K5 → 0001.
  - Repeat with K4 only SUSPECT: K5 evicts K4; QUERY K4 → 0001.
- Request during INIT → out_flag=0000 at T+3. Assert eth_rst with 3 requests in flight → no out_valid afterwards, init_done drops and the sweep restarts.
